// File: rtl/wb_burst_master.sv
// wb_burst_master
// Wishbone B4 burst master. It turns one command descriptor into a classic
// cycle or an incrementing burst toward one of NUM_SLAVES one-hot strobe lines.
// Write data is streamed in and read data is streamed out. The block reports
// completion and bus errors with one-cycle pulses.
//
// Ports
//   clk_i, rst_ni              clock and asynchronous active-low reset
//   cmd_*                      command descriptor with valid/ready handshake
//   wr_data_i/wr_valid_i/wr_ready_o   write data stream, one word per acked beat
//   rd_data_o/rd_valid_o       read data stream (no backpressure)
//   wb_*                       Wishbone master side (muxed slave response in)
//   done_o, err_o              completion pulse, plus error flag on the same cycle
//
// Configuration macro: WB_BURST_WRAP_EN enables wrap-4/8/16 addressing and
// drives wb_bte_o. When it is undefined, the BTE is 00 and addresses increment
// linearly.
module wb_burst_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter int MAX_BURST  = 16,
  localparam int SEL_WIDTH = DATA_WIDTH / 8,
  localparam int LEN_W     = $clog2(MAX_BURST),
  localparam int SLV_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_we_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic [SLV_W-1:0]      cmd_slv_i,
  input  logic [1:0]            cmd_bte_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_we_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  output logic [NUM_SLAVES-1:0] wb_stb_o,
  output logic                  wb_cyc_o,
  output logic [2:0]            wb_cti_o,
  output logic [1:0]            wb_bte_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, BUS, FINISH} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [ADDR_WIDTH-1:0]   adr_next;
  logic [LEN_W-1:0]        cnt;
  logic                    len_zero;
  logic                    we;
  logic [SEL_WIDTH-1:0]    sel;
  logic [SLV_W-1:0]        slv;
  logic [1:0]              bte;
  logic                    err_flag;
  logic                    slv_bad;
  logic                    stb_act;

  // The check is only needed when the index field can encode a missing slave.
  // Otherwise the compare would be constant.
  if (NUM_SLAVES < (1 << SLV_W)) begin : g_slv_chk
    assign slv_bad = (cmd_slv_i >= SLV_W'(NUM_SLAVES));
  end else begin : g_slv_ok
    assign slv_bad = 1'b0;
  end

  // A write beat strobes only while write data is offered. The cycle stays
  // open during a stall.
  assign stb_act     = (state == BUS) && (!we || wr_valid_i);
  assign wb_stb_o    = stb_act ? (NUM_SLAVES'(1) << slv) : '0;
  assign wb_cyc_o    = (state == BUS);
  assign wb_dat_o    = (state == BUS && we) ? wr_data_i : '0;
  assign wr_ready_o  = wb_ack_i && we && stb_act;
  assign cmd_ready_o = (state == IDLE);
  assign done_o      = (state == FINISH);
  assign err_o       = (state == FINISH) && err_flag;
  assign wb_adr_o    = adr;
  assign wb_we_o     = we;
  assign wb_sel_o    = sel;
  assign wb_bte_o    = bte;
  // A single-beat command is a classic cycle. In a burst, only the final
  // beat is tagged end-of-burst.
  assign wb_cti_o    = (state != BUS || len_zero) ? 3'b000 :
                       (cnt == '0) ? 3'b111 : 3'b010;

`ifdef WB_BURST_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] adr_inc;
  always_comb begin
    wrap_mask = '1;
    adr_inc   = adr + 1'b1;
    case (bte)
      2'b01:   wrap_mask = ADDR_WIDTH'(3);
      2'b10:   wrap_mask = ADDR_WIDTH'(7);
      2'b11:   wrap_mask = ADDR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
    // Bits above the wrap window stay fixed. Only the low bits count.
    adr_next = (adr & ~wrap_mask) | (adr_inc & wrap_mask);
  end
`else
  logic unused_bte;
  assign unused_bte = ^cmd_bte_i;
  assign adr_next   = adr + 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      adr        <= '0;
      cnt        <= '0;
      len_zero   <= 1'b0;
      we         <= 1'b0;
      sel        <= '0;
      slv        <= '0;
      bte        <= 2'b00;
      err_flag   <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      case (state)
        IDLE: if (cmd_valid_i) begin
          adr      <= cmd_addr_i;
          cnt      <= cmd_len_i;
          len_zero <= (cmd_len_i == '0);
          we       <= cmd_we_i;
          sel      <= cmd_sel_i;
          slv      <= cmd_slv_i;
`ifdef WB_BURST_WRAP_EN
          bte      <= cmd_bte_i;
`else
          bte      <= 2'b00;
`endif
          // An unreachable slave never gets a strobe. It reports an error at once.
          err_flag <= slv_bad;
          state    <= slv_bad ? FINISH : BUS;
        end
        BUS: if (stb_act) begin
          if (wb_err_i) begin
            err_flag <= 1'b1;
            state    <= FINISH;
          end else if (wb_ack_i) begin
            if (!we) begin
              rd_data_o  <= wb_dat_i;
              rd_valid_o <= 1'b1;
            end
            adr <= adr_next;
            if (cnt == '0) state <= FINISH;
            else           cnt   <= cnt - 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized scoreboard bench for wb_burst_master. The stimulus pushes the
// expected bus beats, read words and completion status. A monitor pops them
// whenever the DUT shows a strobed response, rd_valid_o or done_o. A slave
// model answers from a fixed random memory. It adds optional wait states,
// error injection and stray ack/err while not strobed.
module tb_wb_burst_master;
  localparam int AW = 4, DW = 32, NS = 2, MB = 16;
  localparam int SW = DW / 8, LW = $clog2(MB), NW = (NS > 1) ? $clog2(NS) : 1;
  localparam int NOERR = 99;

  logic clk_i = 0, rst_ni = 0;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_we_i = 0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic [NW-1:0] cmd_slv_i = '0;
  logic [1:0] cmd_bte_i = '0;
  logic [SW-1:0] cmd_sel_i = '0;
  logic [DW-1:0] wr_data_i = 32'hdead_beef, rd_data_o, wb_dat_o, wb_dat_i = '0;
  logic wr_valid_i = 0, wr_ready_o, rd_valid_o, wb_we_o, wb_cyc_o;
  logic [AW-1:0] wb_adr_o;
  logic [SW-1:0] wb_sel_o;
  logic [NS-1:0] wb_stb_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic wb_ack_i = 0, wb_err_i = 0, done_o, err_o;

  wb_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .MAX_BURST(MB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i), .cmd_slv_i(cmd_slv_i),
    .cmd_bte_i(cmd_bte_i), .cmd_sel_i(cmd_sel_i), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i), .done_o(done_o), .err_o(err_o));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NS-1:0] stb; logic [AW-1:0] adr; logic [2:0] cti; logic [1:0] bte;
    logic we; logic [SW-1:0] sel; logic [DW-1:0] dat;
  } beat_t;

  beat_t exp_beats[$];
  logic [DW-1:0] exp_rd[$];
  bit exp_st[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] mem [NS][1 << AW];

  int vectors = 0, miscompares = 0;
  bit mon_en = 1, wait_en = 0, gap_en = 0, noise_en = 0;
  int err_beat = NOERR, sl_beat = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h @%0t", nm, got, exp, $time);
    end
  endtask

  // Expected address of beat i. A wrap burst cycles inside an aligned window
  // of 4/8/16 words. A linear burst wraps at the address space size.
  function automatic logic [AW-1:0] exp_adr(input int start, input int bte, input int i);
    int size, base;
    size = (bte == 0) ? (1 << AW) : (2 << bte);
    if (size > (1 << AW)) size = 1 << AW;
    base = start - (start % size);
    return AW'(base + ((start - base + i) % size));
  endfunction

  // Slave model, driven on the falling edge
  always @(negedge clk_i) begin
    wb_ack_i = 0; wb_err_i = 0; wb_dat_i = $urandom;
    if (wb_stb_o != '0) begin
      if (!(wait_en && $urandom_range(3) == 0)) begin
        if (sl_beat == err_beat) wb_err_i = 1;
        else begin
          wb_ack_i = 1;
          wb_dat_i = mem[wb_stb_o[1] ? 1 : 0][wb_adr_o];
        end
        sl_beat++;
      end
    end else if (noise_en && $urandom_range(7) == 0) begin
      if ($urandom_range(1) == 1) wb_ack_i = 1; else wb_err_i = 1;
    end
  end

  // Write data source: pop on handshake, optionally insert gaps
  always begin
    bit hs;
    @(negedge clk_i); #2;
    hs = wr_valid_i && wr_ready_o;
    @(posedge clk_i); #1;
    if (hs && wq.size() > 0) void'(wq.pop_front());
    if (wq.size() > 0 && !(gap_en && $urandom_range(2) == 0)) begin
      wr_valid_i = 1; wr_data_i = wq[0];
    end else begin
      wr_valid_i = 0; wr_data_i = $urandom;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk_i) begin
    #2;
    if (rst_ni && mon_en) begin
      if (wb_stb_o != '0 && (wb_ack_i || wb_err_i)) begin
        if (exp_beats.size() == 0) check("unexpected_beat", 64'(wb_adr_o), 64'hffff);
        else begin
          beat_t b, g;
          b = exp_beats.pop_front();
          g = '{wb_stb_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_we_o, wb_sel_o, b.we ? wb_dat_o : '0};
          check("beat", 64'(g), 64'(b));
          check("cyc_with_stb", 64'(wb_cyc_o), 64'd1);
        end
      end
      if (rd_valid_o) begin
        if (exp_rd.size() == 0) check("unexpected_rd", 64'(rd_data_o), 64'hffff_ffff_ffff);
        else check("rd_data", 64'(rd_data_o), 64'(exp_rd.pop_front()));
      end
      if (done_o) begin
        if (exp_st.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("err_status", 64'(err_o), 64'(exp_st.pop_front()));
      end else if (err_o) check("err_without_done", 64'd1, 64'd0);
    end
  end

  // Issue one command, push its expectations and wait for completion.
  // The task is entered and left at posedge+1.
  task automatic run_cmd(input bit we, input int slv, input int adr, input int len,
                         input int bte, input int sel, input int eb, input bit w_en, input bit g_en);
    int bte_eff, nb, cyc;
    bit got;
    logic [DW-1:0] wd [MB];
`ifdef WB_BURST_WRAP_EN
    bte_eff = bte;
`else
    bte_eff = 0;
`endif
    wait_en = w_en; gap_en = g_en; err_beat = eb; sl_beat = 0;
    nb = (eb <= len) ? eb + 1 : len + 1;
    for (int i = 0; i <= len; i++) begin
      wd[i] = $urandom;
      if (we) wq.push_back(wd[i]);
    end
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.stb = NS'(1) << slv;
      b.adr = exp_adr(adr, bte_eff, i);
      b.cti = (len == 0) ? 3'b000 : (i == len) ? 3'b111 : 3'b010;
      b.bte = 2'(bte_eff);
      b.we  = we;
      b.sel = SW'(sel);
      b.dat = we ? wd[i] : '0;
      exp_beats.push_back(b);
      if (!we && i != eb) exp_rd.push_back(mem[slv][b.adr]);
    end
    exp_st.push_back(eb <= len);
    cmd_we_i = we; cmd_slv_i = NW'(slv); cmd_addr_i = AW'(adr); cmd_len_i = LW'(len);
    cmd_bte_i = 2'(bte); cmd_sel_i = SW'(sel); cmd_valid_i = 1;
    got = 0;
    repeat (20) begin
      @(negedge clk_i); #2;
      if (cmd_ready_o) begin got = 1; break; end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    cmd_valid_i = 0; cmd_addr_i = $urandom; cmd_len_i = $urandom;
    got = 0; cyc = 0;
    repeat (400) begin
      @(negedge clk_i); #2;
      if (cyc == 0) check("busy_not_ready", 64'(cmd_ready_o), 64'd0);
      if (done_o) begin got = 1; break; end
      cyc++;
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
    else if (!w_en && (!we || !g_en)) check("latency", 64'(cyc), 64'(nb));
    @(negedge clk_i); #2;
    check("ready_after_done", 64'(cmd_ready_o), 64'd1);
    wq.delete();
    @(posedge clk_i); #1;
  endtask

  initial begin
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < (1 << AW); a++) mem[s][a] = $urandom;
    wr_data_i = 32'h5a5a_a5a5;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #2;
    check("reset_state", 64'({cmd_ready_o, wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_we_o,
                              wb_sel_o, wb_dat_o, rd_valid_o, done_o, err_o, wr_ready_o}),
          64'({1'b1, 1'b0, {NS{1'b0}}, {AW{1'b0}}, 3'b0, 2'b0, 1'b0, {SW{1'b0}}, {DW{1'b0}}, 4'b0}));
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(posedge clk_i); #1;

    run_cmd(1, 1, 0, 0, 0, 4'hf, NOERR, 0, 0);
    run_cmd(0, 0, 2, 3, 0, 4'hf, NOERR, 0, 0);
    run_cmd(0, 0, 6, 3, 1, 4'hf, NOERR, 0, 0);
    run_cmd(1, 0, 3, 3, 0, 4'h3, NOERR, 0, 1);
    run_cmd(0, 0, 5, 3, 0, 4'hf, 1, 0, 0);
    run_cmd(0, 1, 9, 7, 2, 4'hc, NOERR, 1, 0);
    run_cmd(1, 1, 14, 15, 3, 4'hf, NOERR, 0, 0);

    // Reset in the middle of a long read: outputs drop at once, no done pulse
    mon_en = 0; wait_en = 0; err_beat = NOERR; sl_beat = 0;
    cmd_we_i = 0; cmd_slv_i = 0; cmd_addr_i = 0; cmd_len_i = LW'(15); cmd_valid_i = 1;
    @(posedge clk_i); #1;
    cmd_valid_i = 0;
    repeat (3) @(posedge clk_i);
    #3 rst_ni = 0;
    #1 check("reset_mid_burst", 64'({wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o, wb_we_o, wb_dat_o,
                                      rd_valid_o, done_o, err_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(negedge clk_i); #2;
    check("ready_after_reset", 64'({cmd_ready_o, done_o}), 64'b10);
    mon_en = 1;
    @(posedge clk_i); #1;
    run_cmd(0, 1, 4, 0, 0, 4'hf, NOERR, 0, 0);

    // Randomized commands
    repeat (60) begin
      int len;
      len = $urandom_range(MB - 1);
      noise_en = ($urandom_range(1) == 1);
      run_cmd($urandom_range(1) == 1, $urandom_range(NS - 1), $urandom_range((1 << AW) - 1), len,
              $urandom_range(3), $urandom_range((1 << SW) - 1),
              ($urandom_range(3) == 0) ? $urandom_range(len) : NOERR,
              $urandom_range(1) == 1, $urandom_range(1) == 1);
      repeat ($urandom_range(2)) @(posedge clk_i);
      #0;
    end
    noise_en = 0;
    repeat (3) @(posedge clk_i);
    check("scoreboard_drained", 64'(exp_beats.size() + exp_rd.size() + exp_st.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Parametrised Wishbone B4 burst master that turns single command descriptors into classic or incrementing-burst cycles toward one of NUM_SLAVES slaves. It drives a per-slave strobe vector and the CTI/BTE tags, streams write data in and read data out, and reports completion and bus errors. It sits between the test/control logic and the multi-slave interconnect, replacing the hand-driven stb/cyc/cti sequencing.

## Interface
- ADDR_WIDTH, 4: word address width.
- DATA_WIDTH, 32: data width; SEL_WIDTH = DATA_WIDTH/8 (derived).
- NUM_SLAVES, 2: number of one-hot strobe lines.
- MAX_BURST, 16: maximum beats per command, power of two, ≥2.
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_addr_i  in  ADDR_WIDTH  start word address.
- cmd_we_i  in  1  1 = write burst.
- cmd_len_i  in  $clog2(MAX_BURST)  beats minus one.
- cmd_slv_i  in  $clog2(NUM_SLAVES)  target slave index.
- cmd_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- cmd_sel_i  in  SEL_WIDTH  byte lanes, held for all beats.
- wr_data_i, wr_valid_i / wr_ready_o  in/in/out  DATA_WIDTH,1,1  write data stream.
- rd_data_o, rd_valid_o  out  DATA_WIDTH,1  read data stream (no backpressure).
- wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o  out  ADDR_WIDTH,DATA_WIDTH,1,SEL_WIDTH  bus signals.
- wb_stb_o  out  NUM_SLAVES  one-hot strobe.
- wb_cyc_o  out  1; wb_cti_o  out  3; wb_bte_o  out  2.
- wb_ack_i, wb_err_i, wb_dat_i  in  1,1,DATA_WIDTH  muxed slave response.
- done_o, err_o  out  1  one-cycle status pulses.

## Operation
- States: IDLE, BUS, FINISH. cmd_ready_o = 1 only in IDLE.
- IDLE: on cmd_valid_i && cmd_ready_o latch descriptor, beat counter = cmd_len_i, go BUS.
- BUS: wb_cyc_o = 1; wb_stb_o[slv] = 1 for reads always, for writes only while wr_valid_i = 1 (cyc held high while stalled). wb_dat_o = wr_data_i; wr_ready_o = wb_ack_i && write && strobe active.
- CTI: cmd_len 0 → 000 (classic) on the sole beat; otherwise 010 on all beats but the last, 111 on the last. wb_bte_o = latched bte.
- On each ack: counter decrements, address advances by 1; with wrap BTE only the low 2/3/4 bits increment, upper bits fixed. Read ack: rd_data_o captured from wb_dat_i, rd_valid_o pulses next cycle.
- Ack on last beat, or wb_err_i on any beat → FINISH (remaining beats abandoned). err_i takes priority over simultaneous ack; errored read beat produces no rd_valid_o.
- FINISH: cyc/stb low, done_o = 1, err_o = 1 if terminated by error; next cycle IDLE.
- ack/err while not strobing ignored. cmd_slv_i ≥ NUM_SLAVES: no strobe asserted, command completes immediately with err_o.

## Timing
- Reset (asynchronous, immediate): state IDLE, cmd_ready_o=1, all wb_* outputs 0, wb_cti_o=000, rd_valid_o, done_o, err_o, wr_ready_o = 0. Reset mid-burst drops cyc/stb in the same instant; no done_o.
- Command accepted at edge N → cyc/stb/adr valid from N+1.
- Zero-wait-state slave: beat k acked at N+1+k; FINISH at N+1+len+1, done_o that cycle; cmd_ready_o high again N+3+len.
- rd_valid_o one cycle after the corresponding ack. wb_adr_o/wb_cti_o update one cycle after ack (registered).
- Minimum gap between commands: one idle cycle (FINISH) plus IDLE acceptance cycle.

## Configuration
- WB_BURST_WRAP_EN defined: BTE 01/10/11 perform wrap addressing and wb_bte_o reflects cmd_bte_i.
- Undefined: cmd_bte_i ignored, wb_bte_o = 00, address always increments linearly (ADDR_WIDTH modulo).

## Test plan
- Single write, slv 1, addr 0, len 0, data 0x0000_1111 → wb_stb_o=2'b10, cti 000, one ack, done_o one cycle later, err_o 0.
- Read burst slv 0, addr 2, len 3, linear → adr 2,3,4,5; cti 010,010,010,111; four rd_valid_o with slave data in order.
- Wrap-4 read, addr 6, bte 01, len 3 (WB_BURST_WRAP_EN) → adr 6,7,4,5; without macro → 6,7,8,9 and wb_bte_o 00.
- Write burst len 3 with wr_valid_i low for 2 cycles before beat 2 → stb drops, cyc stays 1, beat 2 data 0x1111_0000 accepted after resume, exactly four acks.
- wb_err_i on beat 1 of len-3 read → cyc low next cycle, done_o and err_o pulse together, only one rd_valid_o.
- rst_ni asserted mid-burst → all wb_* outputs 0 immediately; after release cmd_ready_o=1 and a new single read completes normally.
